// File: rtl/io_ring_pwr_seq.sv
// io_ring_pwr_seq: staggered pad-group power sequencer for one IO-ring supply segment
module io_ring_pwr_seq #(
  parameter int N_GROUPS    = 4,
  parameter int SETTLE_CYC  = 256,
  parameter int STAGGER_CYC = 16,
  parameter int CNT_W       = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vddq_ok_i,
  input  logic                seq_en_i,
  input  logic                pwr_down_req_i,
  output logic [N_GROUPS-1:0] grp_en_o,
  output logic                iso_n_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                fault_o,
  output logic [2:0]          state_o
);
  typedef enum logic [2:0] {
    OFF = 3'd0, WAIT_SUP = 3'd1, SETTLE = 3'd2, RAMP_UP = 3'd3,
    ON = 3'd4, RAMP_DOWN = 3'd5, FAULT = 3'd6
  } state_t;
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYC - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] timer, timer_d, timer_inc;
  logic [N_GROUPS-1:0] grp_d;
  logic iso_d, fault_d, sync1, vok_s, stop, powered;
  assign timer_inc = &timer ? timer : timer + 1'b1;
  assign stop = pwr_down_req_i | ~seq_en_i;
  assign powered = (state == SETTLE) | (state == RAMP_UP) | (state == ON) | (state == RAMP_DOWN);
  assign state_o = state;
  always_comb begin
    state_d = state;
    timer_d = '0;
    grp_d = grp_en_o;
    iso_d = iso_n_o;
    fault_d = fault_o;
    case (state)
      OFF: state_d = seq_en_i ? WAIT_SUP : OFF;
      WAIT_SUP: state_d = !seq_en_i ? OFF : vok_s ? SETTLE : WAIT_SUP;
      SETTLE: begin
        timer_d = timer_inc;
        if (!seq_en_i) state_d = OFF;
        else if (timer == SET_LAST) begin
          state_d = RAMP_UP;
          grp_d = N_GROUPS'(1);
          timer_d = '0;
        end
      end
      RAMP_UP: begin
        timer_d = timer_inc;
        if (stop) begin
          state_d = RAMP_DOWN;
          timer_d = '0;
        end else if (timer == STG_LAST) begin
          timer_d = '0;
          if (&grp_en_o) begin
            state_d = ON;
            iso_d = 1'b1;
          end else grp_d = (grp_en_o << 1) | N_GROUPS'(1);
        end
      end
      ON: if (stop) begin
        state_d = RAMP_DOWN;
        iso_d = 1'b0;
      end
      RAMP_DOWN: begin
        timer_d = timer_inc;
        if (timer == STG_LAST) begin
          timer_d = '0;
          grp_d = grp_en_o >> 1;
          state_d = (grp_en_o >> 1) == '0 ? OFF : RAMP_DOWN;
        end
      end
      FAULT: if (!seq_en_i) begin
        state_d = OFF;
        fault_d = 1'b0;
      end
      default: state_d = OFF;
    endcase
    // supply loss overrides any request and drops everything at once
    if (powered && !vok_s) begin
      state_d = FAULT;
      timer_d = '0;
      grp_d = '0;
      iso_d = 1'b0;
      fault_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      vok_s <= 1'b0;
      state <= OFF;
      timer <= '0;
      grp_en_o <= '0;
      iso_n_o <= 1'b0;
      ready_o <= 1'b0;
      busy_o <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      sync1 <= vddq_ok_i;
      vok_s <= sync1;
      state <= state_d;
      timer <= timer_d;
      grp_en_o <= grp_d;
      iso_n_o <= iso_d;
      ready_o <= iso_d;
      busy_o <= (state_d == SETTLE) | (state_d == RAMP_UP) | (state_d == RAMP_DOWN);
      fault_o <= fault_d;
    end
  end
endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// tb_io_ring_pwr_seq: directed checks of power-up, power-down, abort, fault, late supply, async reset
module tb_io_ring_pwr_seq;
  logic clk, rst_n, vddq_ok_i, seq_en_i, pwr_down_req_i;
  logic [3:0] grp_en_o;
  logic iso_n_o, ready_o, busy_o, fault_o;
  logic [2:0] state_o;
  int total = 0, bad = 0;

  io_ring_pwr_seq #(.N_GROUPS(4), .SETTLE_CYC(8), .STAGGER_CYC(4), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .vddq_ok_i(vddq_ok_i), .seq_en_i(seq_en_i),
    .pwr_down_req_i(pwr_down_req_i), .grp_en_o(grp_en_o), .iso_n_o(iso_n_o),
    .ready_o(ready_o), .busy_o(busy_o), .fault_o(fault_o), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    int n = 0;
    while (state_o !== s && n < lim) begin
      tick(1);
      n++;
    end
    chk("wait_state", 32'(state_o), 32'(s));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {grp_en_o, iso_n_o, ready_o, busy_o, fault_o, state_o}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    vddq_ok_i = 1'b1;
    seq_en_i = 1'b0;
    pwr_down_req_i = 1'b0;
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    seq_en_i = 1'b1;
    tick(1);
    chk("to_wait_sup", 32'(state_o), 1);
    wait_state(3'd2, 10);
    chk("settle_busy", 32'(busy_o), 1);
    tick(7);
    chk("settle_hold", 32'(grp_en_o), 4'b0000);
    tick(1);
    chk("grp_0001", 32'(grp_en_o), 4'b0001);
    chk("ramp_state", 32'(state_o), 3);
    tick(4);
    chk("grp_0011", 32'(grp_en_o), 4'b0011);
    tick(4);
    chk("grp_0111", 32'(grp_en_o), 4'b0111);
    tick(4);
    chk("grp_1111", 32'(grp_en_o), 4'b1111);
    chk("iso_early", 32'(iso_n_o), 0);
    tick(4);
    chk("on_iso_ready", {iso_n_o, ready_o, busy_o}, 3'b110);
    chk("on_state", 32'(state_o), 4);
    pwr_down_req_i = 1'b1;
    tick(1);
    pwr_down_req_i = 1'b0;
    chk("pd_iso", {iso_n_o, ready_o}, 2'b00);
    chk("pd_state", {state_o, grp_en_o}, {3'd5, 4'b1111});
    tick(4);
    chk("pd_0111", 32'(grp_en_o), 4'b0111);
    tick(4);
    chk("pd_0011", 32'(grp_en_o), 4'b0011);
    tick(4);
    chk("pd_0001", 32'(grp_en_o), 4'b0001);
    tick(4);
    chk("pd_off", {state_o, grp_en_o}, {3'd0, 4'b0000});
    wait_state(3'd3, 50);
    tick(4);
    chk("ab_0011", 32'(grp_en_o), 4'b0011);
    seq_en_i = 1'b0;
    tick(1);
    chk("ab_state", {state_o, grp_en_o, iso_n_o}, {3'd5, 4'b0011, 1'b0});
    tick(3);
    chk("ab_hold", {grp_en_o, iso_n_o}, {4'b0011, 1'b0});
    tick(1);
    chk("ab_0001", {grp_en_o, iso_n_o}, {4'b0001, 1'b0});
    tick(4);
    chk("ab_off", {state_o, grp_en_o, iso_n_o}, {3'd0, 4'b0000, 1'b0});
    seq_en_i = 1'b1;
    wait_state(3'd4, 100);
    vddq_ok_i = 1'b0;
    tick(3);
    chk("flt_out", {grp_en_o, iso_n_o, ready_o, fault_o}, {4'b0000, 3'b001});
    chk("flt_state", 32'(state_o), 6);
    pwr_down_req_i = 1'b1;
    tick(1);
    pwr_down_req_i = 1'b0;
    chk("flt_pd_ignored", {state_o, fault_o}, {3'd6, 1'b1});
    seq_en_i = 1'b0;
    tick(1);
    chk("flt_clear", {state_o, fault_o}, {3'd0, 1'b0});
    seq_en_i = 1'b1;
    tick(1);
    for (int i = 0; i < 50; i++) begin
      chk("late_wait", {state_o, grp_en_o}, {3'd1, 4'b0000});
      tick(1);
    end
    vddq_ok_i = 1'b1;
    tick(1);
    chk("late_sync", 32'(state_o), 1);
    tick(2);
    chk("late_settle", 32'(state_o), 2);
    for (int i = 0; i < 100 && grp_en_o !== 4'b0111; i++) tick(1);
    chk("rst_pre", 32'(grp_en_o), 4'b0111);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #10;
    rst_n = 1'b1;
    chk_all_zero("rst_release");
    tick(1);
    chk("post_rst", 32'(state_o), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
